// File: rtl/regfile_mp.sv
// RISC-V integer register file: two combinational read ports, one byte-enabled write port,
// optional same-cycle write bypass and a hardware clear sweep that runs out of reset or on clr.
module regfile_mp #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 5,
   parameter int unsigned           REG_COUNT  = 32,
   parameter int unsigned           BYPASS     = 1,
   parameter int unsigned           SP_IDX     = 2,
   parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(32'h0000_3FFC)
) (
   input  logic                    CLK,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    WE3,
   input  logic [DATA_WIDTH/8-1:0] BE3,
   input  logic [ADDR_WIDTH-1:0]   A3,
   input  logic [DATA_WIDTH-1:0]   WD3,
   input  logic [ADDR_WIDTH-1:0]   A1,
   input  logic [ADDR_WIDTH-1:0]   A2,
   output logic [DATA_WIDTH-1:0]   RD1,
   output logic [DATA_WIDTH-1:0]   RD2,
   output logic                    busy
);

   localparam int unsigned NB = DATA_WIDTH / 8;

   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   localparam addr_t                 LAST_IDX = addr_t'(REG_COUNT - 1);
   localparam logic [ADDR_WIDTH:0]   REG_LIM  = (ADDR_WIDTH + 1)'(REG_COUNT);

   state_t state_q, state_d;
   addr_t  idx_q, idx_d;
   // Register 0 has no storage; the array starts at index 1.
   word_t  mem_q [1:REG_COUNT-1];
   word_t  mem_d [1:REG_COUNT-1];
   logic   wr_hit;

   function automatic word_t merge(input word_t old_v, input word_t new_v,
                                   input logic [NB-1:0] be);
      word_t r;
      r = old_v;
      for (int unsigned k = 0; k < NB; k++) begin
         if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
      end
      return r;
   endfunction

   assign busy   = (state_q == S_CLEAR);
   assign wr_hit = (state_q == S_IDLE) && !clr && WE3 && (A3 != '0) && ({1'b0, A3} < REG_LIM);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mem_d   = mem_q;
      if (rst) begin
         state_d = S_CLEAR;
         idx_d   = '0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               for (int unsigned i = 1; i < REG_COUNT; i++) begin
                  if (idx_q == addr_t'(i)) mem_d[i] = (i == SP_IDX) ? SP_INIT : '0;
               end
               if (clr) begin
                  idx_d = '0;
               end else if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            default: begin
               if (clr) begin
                  state_d = S_CLEAR;
                  idx_d   = '0;
               end else if (wr_hit) begin
                  for (int unsigned i = 1; i < REG_COUNT; i++) begin
                     if (A3 == addr_t'(i)) mem_d[i] = merge(mem_q[i], WD3, BE3);
                  end
               end
            end
         endcase
      end
   end

   // Unmatched addresses (x0 and >= REG_COUNT) fall through to zero.
   always_comb begin
      RD1 = '0;
      RD2 = '0;
      for (int unsigned i = 1; i < REG_COUNT; i++) begin
         if (A1 == addr_t'(i)) RD1 = mem_q[i];
         if (A2 == addr_t'(i)) RD2 = mem_q[i];
      end
      if (BYPASS != 0 && wr_hit) begin
         if (A1 == A3) RD1 = merge(RD1, WD3, BE3);
         if (A2 == A3) RD2 = merge(RD2, WD3, BE3);
      end
      if (busy) begin
         RD1 = '0;
         RD2 = '0;
      end
   end

   always_ff @(posedge CLK) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances against a behavioural model,
// plus a 64-bit / 16-entry variant checked with literal expectations.
module tb_regfile_mp;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst, clr, WE3;
   logic [3:0]  BE3;
   logic [4:0]  A1, A2, A3;
   logic [31:0] WD3;
   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic        busy_b, busy_n;

   logic        v_rst, v_clr, v_we;
   logic [7:0]  v_be;
   logic [4:0]  v_a1, v_a2, v_a3;
   logic [63:0] v_wd, v_rd1, v_rd2;
   logic        v_busy;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   regfile_mp dut_byp (
      .CLK(CLK), .rst(rst), .clr(clr), .WE3(WE3), .BE3(BE3), .A3(A3), .WD3(WD3),
      .A1(A1), .A2(A2), .RD1(rd1_b), .RD2(rd2_b), .busy(busy_b));

   regfile_mp #(.BYPASS(0)) dut_nb (
      .CLK(CLK), .rst(rst), .clr(clr), .WE3(WE3), .BE3(BE3), .A3(A3), .WD3(WD3),
      .A1(A1), .A2(A2), .RD1(rd1_n), .RD2(rd2_n), .busy(busy_n));

   regfile_mp #(.DATA_WIDTH(64), .REG_COUNT(16), .SP_IDX(3)) dut_w (
      .CLK(CLK), .rst(v_rst), .clr(v_clr), .WE3(v_we), .BE3(v_be), .A3(v_a3), .WD3(v_wd),
      .A1(v_a1), .A2(v_a2), .RD1(v_rd1), .RD2(v_rd2), .busy(v_busy));

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // Behavioural model: register contents plus number of sweep edges still to go.
   logic [31:0] mm [32];
   int          busy_left = 0;

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                       input logic [3:0] be);
      for (int k = 0; k < 4; k++) if (be[k]) o[8*k +: 8] = n[8*k +: 8];
      return o;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
      logic [31:0] v;
      if (busy_left > 0 || a == 5'd0) return 32'h0;
      v = mm[a];
      if (byp && WE3 && !clr && A3 != 5'd0 && A3 == a) v = mrg(v, WD3, BE3);
      return v;
   endfunction

   always @(posedge CLK) begin
      if (rst) begin
         busy_left = 32;
      end else if (busy_left > 0) begin
         if (clr) begin
            busy_left = 32;
         end else begin
            busy_left--;
            if (busy_left == 0)
               for (int i = 0; i < 32; i++) mm[i] = (i == 2) ? 32'h0000_3FFC : 32'h0;
         end
      end else if (clr) begin
         busy_left = 32;
      end else if (WE3 && A3 != 5'd0) begin
         mm[A3] = mrg(mm[A3], WD3, BE3);
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk($sformatf("byp RD1 x%0d", A1), rd1_b, exp_rd(A1, 1'b1));
         chk($sformatf("byp RD2 x%0d", A2), rd2_b, exp_rd(A2, 1'b1));
         chk("byp busy", busy_b, busy_left > 0);
         chk($sformatf("nb RD1 x%0d", A1), rd1_n, exp_rd(A1, 1'b0));
         chk($sformatf("nb RD2 x%0d", A2), rd2_n, exp_rd(A2, 1'b0));
         chk("nb busy", busy_n, busy_left > 0);
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic at_neg();
      @(negedge CLK);
      #1;
   endtask

   // Counts busy cycles until the sweep ends (bounded); walks the read addresses meanwhile.
   task automatic wait_sweep(output int cnt, input bit do_wr);
      cnt = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge CLK);
         #1;
         if (!busy_b) break;
         cnt++;
         A1 = 5'(cnt);
         A2 = 5'(31 - cnt);
         if (do_wr && cnt == 5) begin
            WE3 = 1'b1; A3 = 5'd4; WD3 = 32'hCAFE_F00D; BE3 = 4'hF;
         end
         if (cnt == 6) WE3 = 1'b0;
      end
   endtask

   initial begin
      int cnt;
      int vcnt;
      rst = 1'b1; clr = 1'b0; WE3 = 1'b0; BE3 = 4'h0;
      A1 = 5'd0; A2 = 5'd0; A3 = 5'd0; WD3 = 32'h0;
      v_rst = 1'b1; v_clr = 1'b0; v_we = 1'b0; v_be = 8'h0;
      v_a1 = 5'd0; v_a2 = 5'd0; v_a3 = 5'd0; v_wd = 64'h0;

      // Reset sweep
      cyc();
      rst = 1'b0;
      chk_en = 1'b1;
      A1 = 5'd2;
      #1;
      chk("reset busy", busy_b, 1'b1);
      chk("reset RD1", rd1_b, 32'h0);
      wait_sweep(cnt, 1'b1);
      chk("reset sweep length", cnt, 32);
      A1 = 5'd2; A2 = 5'd4;
      #1;
      chk("x2 sp init", rd1_b, 32'h0000_3FFC);
      chk("x4 write during busy", rd2_b, 32'h0);
      chk("nb x2 sp init", rd1_n, 32'h0000_3FFC);

      // Byte-enable write
      cyc(); WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hAABB_CCDD; BE3 = 4'hF; A1 = 5'd5;
      cyc(); WD3 = 32'h1122_3344; BE3 = 4'b0101;
      cyc(); WE3 = 1'b0;
      at_neg();
      chk("be merge", rd1_b, 32'hAA22_CC44);
      chk("nb be merge", rd1_n, 32'hAA22_CC44);
      cyc(); WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h9988_7766; BE3 = 4'b0011; A2 = 5'd5;
      at_neg();
      chk("partial bypass", rd1_b, 32'hAA22_7766);
      chk("nb partial no bypass", rd1_n, 32'hAA22_CC44);
      cyc(); BE3 = 4'h0; WD3 = 32'hFFFF_FFFF;
      at_neg();
      chk("be0 noop", rd1_b, 32'hAA22_7766);
      cyc(); WE3 = 1'b0;

      // Register 0 and bypass
      cyc(); WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h0BAD_F00D; BE3 = 4'hF; A1 = 5'd0; A2 = 5'd0;
      cyc(); A3 = 5'd0; WD3 = 32'hFFFF_FFFF;
      at_neg();
      chk("x0 write rd1", rd1_b, 32'h0);
      chk("x0 write rd2", rd2_b, 32'h0);
      cyc(); A3 = 5'd7; WD3 = 32'h1234_5678; A1 = 5'd7; A2 = 5'd7;
      at_neg();
      chk("bypass rd1", rd1_b, 32'h1234_5678);
      chk("bypass rd2", rd2_b, 32'h1234_5678);
      chk("nb old x7", rd1_n, 32'h0BAD_F00D);
      cyc(); WE3 = 1'b0;
      at_neg();
      chk("nb new x7", rd1_n, 32'h1234_5678);
      A1 = 5'd0;
      #1;
      chk("x0 reads zero", rd1_b, 32'h0);

      // clr versus write
      cyc(); WE3 = 1'b1; A3 = 5'd9; WD3 = 32'hDEAD_BEEF; BE3 = 4'hF; A1 = 5'd9;
      cyc(); clr = 1'b1; WD3 = 32'h5555_5555;
      at_neg();
      chk("clr blocks bypass", rd1_b, 32'hDEAD_BEEF);
      cyc(); clr = 1'b0; WE3 = 1'b0;
      chk("busy after clr", busy_b, 1'b1);
      wait_sweep(cnt, 1'b0);
      chk("clr sweep length", cnt, 32);
      A1 = 5'd9;
      #1;
      chk("x9 cleared", rd1_b, 32'h0);

      // Mid-sweep restart
      cyc(); clr = 1'b1;
      cyc(); clr = 1'b0;
      repeat (20) cyc();
      chk("busy at idx 20", busy_b, 1'b1);
      clr = 1'b1;
      cyc(); clr = 1'b0;
      wait_sweep(cnt, 1'b0);
      chk("restart sweep length", cnt, 32);
      for (int i = 0; i < 32; i++) begin
         cyc(); A1 = 5'(i); A2 = 5'(31 - i);
      end
      cyc(); A1 = 5'd2; A2 = 5'd7;
      #1;
      chk("restart x2", rd1_b, 32'h0000_3FFC);
      chk("restart x7", rd2_b, 32'h0);

      // 64-bit, 16-entry variant
      cyc(); v_rst = 1'b0;
      vcnt = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge CLK);
         #1;
         if (!v_busy) break;
         vcnt++;
      end
      chk("w sweep length", vcnt, 16);
      v_a1 = 5'd3; v_a2 = 5'd20;
      #1;
      chk("w x3 sp init", v_rd1, 64'h0000_0000_0000_3FFC);
      chk("w read 20", v_rd2, 64'h0);
      cyc(); v_we = 1'b1; v_a3 = 5'd20; v_wd = '1; v_be = '1;
      at_neg();
      chk("w out-of-range bypass", v_rd2, 64'h0);
      cyc(); v_a3 = 5'd15; v_wd = 64'h1122_3344_5566_7788; v_be = 8'h0F; v_a1 = 5'd15;
      at_neg();
      chk("w bypass", v_rd1, 64'h0000_0000_5566_7788);
      cyc(); v_we = 1'b0;
      at_neg();
      chk("w stored x15", v_rd1, 64'h0000_0000_5566_7788);
      chk("w read 20 after write", v_rd2, 64'h0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
      $fatal(1);
   end

endmodule
